// File: rtl/por_reset_sequencer.sv
// por_reset_sequencer: filtered power-on reset release sequencing io -> periph -> core with soft-reset hold
// Ports: clk; resetb (async active-low, from POR); clk_stable_i, ext_resetb_i (async, synchronized);
// sw_reset_req_i (sync pulse, honoured only in RUN); io/periph/core_rstn_o (active-low domain resets);
// seq_done_o (all domains released); state_o (FSM encoding).
module por_reset_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 16,
    parameter int STAGE_DELAY   = 8
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       clk_stable_i,
    input  logic       ext_resetb_i,
    input  logic       sw_reset_req_i,
    output logic       io_rstn_o,
    output logic       periph_rstn_o,
    output logic       core_rstn_o,
    output logic       seq_done_o,
    output logic [2:0] state_o
);
    localparam int MAXC = FILTER_CYCLES > STAGE_DELAY ? FILTER_CYCLES : STAGE_DELAY;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] FLT_END = CW'(FILTER_CYCLES - 1);
    localparam logic [CW-1:0] STG_END = CW'(STAGE_DELAY - 1);

    typedef enum logic [2:0] {
        WAIT    = 3'd0,
        IO      = 3'd1,
        PERIPH  = 3'd2,
        RUN     = 3'd3,
        SW_HOLD = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync, er_sync;
    logic [CW-1:0]          cnt_q, cnt_n;
    logic [2:0]             state_q;
    state_t                 state_n;
    logic                   qual, stg_done;

    assign qual     = cs_sync[SYNC_STAGES-1] & er_sync[SYNC_STAGES-1];
    assign stg_done = cnt_q >= STG_END;
    assign state_o  = state_q;

    // Counter is cleared on every transition and held at zero in RUN, so it never exceeds its limit.
    always_comb begin
        state_n = WAIT;
        cnt_n   = '0;
        if (qual) begin
            case (state_q)
                WAIT: begin
                    state_n = cnt_q >= FLT_END ? IO : WAIT;
                    cnt_n   = cnt_q >= FLT_END ? '0 : cnt_q + 1'b1;
                end
                IO: begin
                    state_n = stg_done ? PERIPH : IO;
                    cnt_n   = stg_done ? '0 : cnt_q + 1'b1;
                end
                PERIPH: begin
                    state_n = stg_done ? RUN : PERIPH;
                    cnt_n   = stg_done ? '0 : cnt_q + 1'b1;
                end
                RUN: state_n = sw_reset_req_i ? SW_HOLD : RUN;
                SW_HOLD: begin
                    state_n = stg_done ? IO : SW_HOLD;
                    cnt_n   = stg_done ? '0 : cnt_q + 1'b1;
                end
                default: state_n = WAIT;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they only move on clock edges.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cs_sync       <= '0;
            er_sync       <= '0;
            cnt_q         <= '0;
            state_q       <= WAIT;
            io_rstn_o     <= 1'b0;
            periph_rstn_o <= 1'b0;
            core_rstn_o   <= 1'b0;
            seq_done_o    <= 1'b0;
        end else begin
            cs_sync       <= {cs_sync[SYNC_STAGES-2:0], clk_stable_i};
            er_sync       <= {er_sync[SYNC_STAGES-2:0], ext_resetb_i};
            cnt_q         <= cnt_n;
            state_q       <= state_n;
            io_rstn_o     <= state_n == IO || state_n == PERIPH || state_n == RUN || state_n == SW_HOLD;
            periph_rstn_o <= state_n == PERIPH || state_n == RUN;
            core_rstn_o   <= state_n == RUN;
            seq_done_o    <= state_n == RUN;
        end
    end
endmodule

// File: doc/por_reset_sequencer.md
POR_RESET_SEQUENCER -- requirements
Module: por_reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for asynchronous inputs (min 2).
REQ-002 SHALL have parameter FILTER_CYCLES, default 16, consecutive qualified cycles required before first release (min 1).
REQ-003 SHALL have parameter STAGE_DELAY, default 8, cycles between successive domain releases (min 1).
REQ-004 SHALL have port: clk  input  1  sequencer clock.
REQ-005 SHALL have port: resetb  input  1  asynchronous active-low reset, driven by the power-on-reset porb output.
REQ-006 SHALL have port: clk_stable_i  input  1  asynchronous; 1 = oscillator/PLL stable.
REQ-007 SHALL have port: ext_resetb_i  input  1  asynchronous active-low external reset pad.
REQ-008 SHALL have port: sw_reset_req_i  input  1  synchronous single-cycle soft-reset request.
REQ-009 SHALL have port: io_rstn_o  output  1  active-low reset, IO domain.
REQ-010 SHALL have port: periph_rstn_o  output  1  active-low reset, peripheral domain.
REQ-011 SHALL have port: core_rstn_o  output  1  active-low reset, core domain.
REQ-012 SHALL have port: seq_done_o  output  1  1 = all domains released.
REQ-013 SHALL have port: state_o  output  3  current FSM state encoding.

Function
REQ-014 SHALL pass clk_stable_i and ext_resetb_i each through SYNC_STAGES flops reset to 0; "qualified" = both synchronized values 1.
REQ-015 SHALL implement FSM states WAIT=0, IO=1, PERIPH=2, RUN=3, SW_HOLD=4; encodings 5-7 SHALL go to WAIT next cycle.
REQ-016 SHALL register all outputs; outputs change only on clk edges or asynchronous reset.
REQ-017 WAIT: filter counter increments each qualified cycle, clears on any unqualified cycle; on the edge where counter reaches FILTER_CYCLES, go IO, set io_rstn_o=1, clear counter.
REQ-018 IO: counter increments each cycle; after STAGE_DELAY edges go PERIPH, set periph_rstn_o=1.
REQ-019 PERIPH: after STAGE_DELAY edges go RUN, set core_rstn_o=1 and seq_done_o=1 on the same edge.
REQ-020 RUN: sw_reset_req_i=1 -> SW_HOLD next edge, core_rstn_o=0, periph_rstn_o=0, seq_done_o=0, io_rstn_o stays 1.
REQ-021 SW_HOLD: after STAGE_DELAY edges go IO with counter cleared, then resume REQ-018/REQ-019 release order.
REQ-022 sw_reset_req_i SHALL be ignored in every state except RUN.
REQ-023 Any state other than WAIT with an unqualified cycle -> WAIT next edge; all four outputs 0; counter cleared.
REQ-024 Loss of qualification SHALL take priority over sw_reset_req_i in the same cycle.
REQ-025 Release order SHALL always be io, then periph, then core; a domain SHALL never be released before its predecessor.
REQ-026 Counter SHALL be sized ceil(log2(max(FILTER_CYCLES,STAGE_DELAY)+1)) bits and SHALL never wrap.

Reset
REQ-027 resetb=0 SHALL asynchronously force state WAIT, counter 0, synchronizer flops 0, io_rstn_o=periph_rstn_o=core_rstn_o=0, seq_done_o=0, state_o=0.
REQ-028 resetb assertion mid-sequence SHALL abort the sequence immediately with no output glitching high.
REQ-029 After resetb deasserts, the sequence SHALL restart from WAIT with full filtering.

Verification
REQ-030 Defaults; clk_stable_i=ext_resetb_i=1 held; resetb released before edge 1 -> io_rstn_o rises at edge 18, periph at 26, core and seq_done_o at 34; state_o 0->1->2->3.
REQ-031 Defaults; ext_resetb_i low for 1 cycle at edge 10 -> filter restarts; io_rstn_o rises no earlier than edge 10+2+16.
REQ-032 In RUN, pulse sw_reset_req_i 1 cycle -> next edge core/periph=0, io stays 1, state_o=4; periph returns 16 edges later, core 24 edges later.
REQ-033 In RUN, clk_stable_i drops and sw_reset_req_i=1 same cycle -> after sync delay all outputs 0, state_o=0, no SW_HOLD entry.
REQ-034 resetb asserted while in PERIPH -> all outputs 0 asynchronously within the same cycle; release then repeats REQ-030 timing.
REQ-035 Parameters SYNC_STAGES=3, FILTER_CYCLES=1, STAGE_DELAY=1 -> io at edge 4, periph at 5, core at 6.
